// File: rtl/cpu_ctrl_mc_pkg.sv
// Shared constants for the multicycle controller and the datapath:
// state codes, opcode/op fields, nsel/vsel mux encodings, strobe bundle.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,  S_IF1   = 4'd1,  S_IF2    = 4'd2,  S_UPC    = 4'd3,
    S_DEC    = 4'd4,  S_WR_IMM = 4'd5, S_GET_A  = 4'd6,  S_GET_B  = 4'd7,
    S_EXEC   = 4'd8,  S_WR_REG = 4'd9, S_ADDR   = 4'd10, S_LATCH  = 4'd11,
    S_MEM_RD = 4'd12, S_MEM_WR = 4'd13, S_HALT  = 4'd14, S_ERR    = 4'd15
  } state_t;

  localparam logic [2:0] OPC_LDR = 3'b011;
  localparam logic [2:0] OPC_STR = 3'b100;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_HLT = 3'b111;

  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_MOVI = 2'b10;

  localparam logic [1:0] NSEL_RN = 2'd0;
  localparam logic [1:0] NSEL_RD = 2'd1;
  localparam logic [1:0] NSEL_RM = 2'd2;

  localparam logic [1:0] VSEL_C     = 2'd0;
  localparam logic [1:0] VSEL_PC    = 2'd1;
  localparam logic [1:0] VSEL_IMM8  = 2'd2;
  localparam logic [1:0] VSEL_MDATA = 2'd3;

  // All controller strobes, built in one place and fanned out to the bus.
  typedef struct packed {
    logic       loadir;
    logic       loadpc;
    logic       pc_rst;
    logic       msel;
    logic       mwrite;
    logic       load_addr;
    logic [1:0] nsel;
    logic [1:0] vsel;
    logic       write;
    logic       asel;
    logic       bsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/cpu_ctrl_mc_if.sv
// Controller <-> datapath bus: decode fields in, strobes and debug state out.
interface cpu_ctrl_mc_if #(parameter int STATE_W = 5);
  logic [2:0]         opcode;
  logic [1:0]         op;
  logic               loadir, loadpc, pc_rst, msel, mwrite, load_addr;
  logic [1:0]         nsel, vsel;
  logic               write, asel, bsel, loada, loadb, loadc, loads, halted;
  logic [STATE_W-1:0] state;

  // Controller side
  modport master (
    input  opcode, op,
    output loadir, loadpc, pc_rst, msel, mwrite, load_addr, nsel, vsel,
           write, asel, bsel, loada, loadb, loadc, loads, halted, state
  );

  // Datapath side
  modport slave (
    output opcode, op,
    input  loadir, loadpc, pc_rst, msel, mwrite, load_addr, nsel, vsel,
           write, asel, bsel, loada, loadb, loadc, loads, halted, state
  );
endinterface

// File: rtl/cpu_ctrl_mc_wait_cnt.sv
// Memory wait-state counter: cleared on state entry, counts while the
// state is held, done once the count reaches MEM_WAIT.
module cpu_wait_cnt #(parameter int MEM_WAIT = 1) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic done
);
  localparam logic [3:0] WAIT_V = 4'(MEM_WAIT);

  logic [3:0] cnt;

  assign done = (cnt == WAIT_V);

  // Clear wins; saturate at the target so a held state never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (!done)  cnt <= cnt + 4'd1;
  end
endmodule

// File: rtl/cpu_ctrl_mc.sv
// Multicycle controller FSM for the 16-bit teaching CPU.
// Optional macro CPU_CTRL_STEP_EN: adds a 'step' input; UPC waits for a
// step rising edge before decoding (one instruction per key press).
module cpu_ctrl_mc
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int STATE_W  = 5
) (
  input  logic clk,
  input  logic reset,
`ifdef CPU_CTRL_STEP_EN
  input  logic step,
`endif
  cpu_ctrl_mc_if.master bus
);
  state_t st, st_n;
  ctrl_t  c;
  logic   wait_done, cnt_clr, step_go;

`ifdef CPU_CTRL_STEP_EN
  logic step_q;
  // Registered edge detector on the step key.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) step_q <= 1'b0;
    else        step_q <= step;
  end
  assign step_go = step & ~step_q;
`else
  assign step_go = 1'b1;
`endif

  cpu_wait_cnt #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk   (clk),
    .rst_n (reset),
    .clr   (cnt_clr),
    .done  (wait_done)
  );

  // Any state change restarts the wait count, so each wait state starts at 0.
  assign cnt_clr = (st_n != st);

  // State register; reset aborts immediately to RST.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= S_RST;
    else        st <= st_n;
  end

  // Next state and Moore strobes (decode fields refine a few states).
  always_comb begin
    st_n = st;
    c    = '0;
    unique case (st)
      S_RST: begin
        c.loadpc = 1'b1;
        c.pc_rst = 1'b1;
        st_n     = S_IF1;
      end
      S_IF1: begin
        c.msel = 1'b1;
        if (wait_done) st_n = S_IF2;
      end
      S_IF2: begin
        c.msel   = 1'b1;
        c.loadir = 1'b1;
        st_n     = S_UPC;
      end
      S_UPC: begin
        // Increment only on the exit cycle so a stepped wait bumps PC once.
        c.loadpc = step_go;
        if (step_go) st_n = S_DEC;
      end
      S_DEC: begin
        if (bus.opcode == OPC_MOV && bus.op == OP_MOVI)      st_n = S_WR_IMM;
        else if (bus.opcode == OPC_MOV && bus.op == OP_MOVR) st_n = S_GET_B;
        else if (bus.opcode == OPC_ALU || bus.opcode == OPC_LDR ||
                 bus.opcode == OPC_STR)                      st_n = S_GET_A;
        else if (bus.opcode == OPC_HLT)                      st_n = S_HALT;
        else                                                 st_n = S_ERR;
      end
      S_WR_IMM: begin
        c.nsel  = NSEL_RN;
        c.vsel  = VSEL_IMM8;
        c.write = 1'b1;
        st_n    = S_IF1;
      end
      S_GET_A: begin
        c.nsel  = NSEL_RN;
        c.loada = 1'b1;
        st_n    = (bus.opcode == OPC_ALU) ? S_GET_B : S_ADDR;
      end
      S_GET_B: begin
        c.nsel  = (bus.opcode == OPC_STR) ? NSEL_RD : NSEL_RM;
        c.loadb = 1'b1;
        st_n    = S_EXEC;
      end
      S_EXEC: begin
        if (bus.opcode == OPC_ALU && bus.op == OP_CMP) begin
          c.loads = 1'b1;
          st_n    = S_IF1;
        end else begin
          c.loadc = 1'b1;
          c.asel  = (bus.opcode != OPC_ALU);
          st_n    = (bus.opcode == OPC_STR) ? S_MEM_WR : S_WR_REG;
        end
      end
      S_WR_REG: begin
        c.nsel  = NSEL_RD;
        c.vsel  = (bus.opcode == OPC_LDR) ? VSEL_MDATA : VSEL_C;
        c.write = 1'b1;
        st_n    = S_IF1;
      end
      S_ADDR: begin
        c.bsel  = 1'b1;
        c.loadc = 1'b1;
        st_n    = S_LATCH;
      end
      S_LATCH: begin
        c.load_addr = 1'b1;
        st_n        = (bus.opcode == OPC_LDR) ? S_MEM_RD : S_GET_B;
      end
      S_MEM_RD: begin
        if (wait_done) st_n = S_WR_REG;
      end
      S_MEM_WR: begin
        c.mwrite = 1'b1;
        if (wait_done) st_n = S_IF1;
      end
      S_HALT, S_ERR: begin
        c.halted = 1'b1;
      end
      default: st_n = S_ERR;
    endcase
  end

  assign bus.loadir    = c.loadir;
  assign bus.loadpc    = c.loadpc;
  assign bus.pc_rst    = c.pc_rst;
  assign bus.msel      = c.msel;
  assign bus.mwrite    = c.mwrite;
  assign bus.load_addr = c.load_addr;
  assign bus.nsel      = c.nsel;
  assign bus.vsel      = c.vsel;
  assign bus.write     = c.write;
  assign bus.asel      = c.asel;
  assign bus.bsel      = c.bsel;
  assign bus.loada     = c.loada;
  assign bus.loadb     = c.loadb;
  assign bus.loadc     = c.loadc;
  assign bus.loads     = c.loads;
  assign bus.halted    = c.halted;
  assign bus.state     = STATE_W'(st);

endmodule

// File: tb/tb_cpu_ctrl_mc.sv
// Bench for cpu_ctrl_mc: two instances (MEM_WAIT=2 and MEM_WAIT=1), each
// exercised while the other is held in reset. Expected state traces are
// built per instruction class from the instruction flow; strobes per state.
module tb_cpu_ctrl_mc;
  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [2:0] opc;
  logic [1:0] opp;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  cpu_ctrl_mc_if #(.STATE_W(5)) ifa ();
  cpu_ctrl_mc_if #(.STATE_W(5)) ifb ();

  assign ifa.opcode = opc;
  assign ifa.op     = opp;
  assign ifb.opcode = opc;
  assign ifb.op     = opp;

  cpu_ctrl_mc #(.MEM_WAIT(2), .STATE_W(5)) dut_a (
    .clk   (clk),
    .reset (rst_a),
`ifdef CPU_CTRL_STEP_EN
    .step  (1'b0),
`endif
    .bus   (ifa)
  );

  cpu_ctrl_mc #(.MEM_WAIT(1), .STATE_W(5)) dut_b (
    .clk   (clk),
    .reset (rst_b),
`ifdef CPU_CTRL_STEP_EN
    .step  (1'b0),
`endif
    .bus   (ifb)
  );

  wire [17:0] oa = {ifa.loadir, ifa.loadpc, ifa.pc_rst, ifa.msel, ifa.mwrite,
                    ifa.load_addr, ifa.nsel, ifa.vsel, ifa.write, ifa.asel,
                    ifa.bsel, ifa.loada, ifa.loadb, ifa.loadc, ifa.loads,
                    ifa.halted};
  wire [17:0] ob = {ifb.loadir, ifb.loadpc, ifb.pc_rst, ifb.msel, ifb.mwrite,
                    ifb.load_addr, ifb.nsel, ifb.vsel, ifb.write, ifb.asel,
                    ifb.bsel, ifb.loada, ifb.loadb, ifb.loadc, ifb.loads,
                    ifb.halted};

  // Strobes required in each state (state codes as plain numbers).
  function automatic logic [17:0] exp_out(int s, logic [2:0] o, logic [1:0] p);
    logic ir, lpc, prst, ms, mw, la, wr, as, bs, lda, ldb, ldc, lds, hlt;
    logic [1:0] ns, vs;
    {ir, lpc, prst, ms, mw, la, wr, as, bs, lda, ldb, ldc, lds, hlt} = '0;
    ns = 2'd0; vs = 2'd0;
    case (s)
      0:  begin lpc = 1; prst = 1; end
      1:  ms = 1;
      2:  begin ms = 1; ir = 1; end
      3:  lpc = 1;
      5:  begin ns = 2'd0; vs = 2'd2; wr = 1; end
      6:  begin ns = 2'd0; lda = 1; end
      7:  begin ldb = 1; ns = (o == 3'b100) ? 2'd1 : 2'd2; end
      8:  begin
            if (o == 3'b101 && p == 2'b01) lds = 1;
            else ldc = 1;
            as = (o == 3'b101) ? 1'b0 : 1'b1;
          end
      9:  begin ns = 2'd1; wr = 1; vs = (o == 3'b011) ? 2'd3 : 2'd0; end
      10: begin bs = 1; ldc = 1; end
      11: la = 1;
      13: mw = 1;
      14, 15: hlt = 1;
      default: ;
    endcase
    return {ir, lpc, prst, ms, mw, la, ns, vs, wr, as, bs, lda, ldb, ldc, lds, hlt};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction from its first IF1 cycle; on return the DUT is in
  // the last cycle of that instruction (HALT/ERR: four cycles of residency).
  task automatic run_instr(input bit b, input logic [2:0] o, input logic [1:0] p);
    int w;
    int q[$];
    w = b ? 1 : 2;
    q = {};
    repeat (w + 1) q.push_back(1);
    q.push_back(2); q.push_back(3); q.push_back(4);
    if (o == 3'b110 && p == 2'b10) q.push_back(5);
    else if (o == 3'b110 && p == 2'b00) begin q.push_back(7); q.push_back(8); q.push_back(9); end
    else if (o == 3'b101) begin
      q.push_back(6); q.push_back(7); q.push_back(8);
      if (p != 2'b01) q.push_back(9);
    end
    else if (o == 3'b011) begin
      q.push_back(6); q.push_back(10); q.push_back(11);
      repeat (w + 1) q.push_back(12);
      q.push_back(9);
    end
    else if (o == 3'b100) begin
      q.push_back(6); q.push_back(10); q.push_back(11); q.push_back(7); q.push_back(8);
      repeat (w + 1) q.push_back(13);
    end
    else if (o == 3'b111) repeat (4) q.push_back(14);
    else repeat (4) q.push_back(15);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      chk($sformatf("state dut%0d opc=%b op=%b cyc%0d", b, o, p, i),
          32'(b ? ifb.state : ifa.state), 32'(q[i]));
      chk($sformatf("strobes dut%0d opc=%b op=%b st=%0d", b, o, p, q[i]),
          32'(b ? ob : oa), 32'(exp_out(q[i], o, p)));
      if (i == 0) begin opc = o; opp = p; end
    end
  endtask

  task automatic rand_instr(input bit b);
    int r;
    logic [1:0] p;
    r = $urandom_range(0, 4);
    p = 2'($urandom_range(0, 3));
    case (r)
      0: run_instr(b, 3'b110, 2'b10);
      1: run_instr(b, 3'b110, 2'b00);
      2: run_instr(b, 3'b101, p);
      3: run_instr(b, 3'b011, p);
      default: run_instr(b, 3'b100, p);
    endcase
  endtask

  initial begin
    bit found;
    rst_a = 1'b0; rst_b = 1'b0; opc = 3'b000; opp = 2'b00;

    // Reset held for three cycles on both instances.
    repeat (3) begin
      @(negedge clk);
      chk("rst state a", 32'(ifa.state), 32'd0);
      chk("rst strobes a", 32'(oa), 32'(exp_out(0, 3'b000, 2'b00)));
      chk("rst state b", 32'(ifb.state), 32'd0);
    end
    rst_a = 1'b1;

    // MEM_WAIT=2 instance: directed then random, ending in HALT.
    run_instr(0, 3'b110, 2'b10);
    run_instr(0, 3'b101, 2'b01);
    run_instr(0, 3'b101, 2'b00);
    run_instr(0, 3'b100, 2'b00);
    run_instr(0, 3'b011, 2'b00);
    run_instr(0, 3'b110, 2'b00);
    repeat (20) rand_instr(0);
    run_instr(0, 3'b111, 2'($urandom_range(0, 3)));

    rst_a = 1'b0;
    #1;
    chk("halt reset state a", 32'(ifa.state), 32'd0);
    chk("halt reset strobes a", 32'(oa), 32'(exp_out(0, 3'b000, 2'b00)));
    rst_b = 1'b1;

    // MEM_WAIT=1 instance.
    run_instr(1, 3'b100, 2'b11);
    run_instr(1, 3'b011, 2'b10);
    run_instr(1, 3'b101, 2'b01);
    repeat (20) rand_instr(1);
    run_instr(1, 3'b000, 2'b00);
    repeat (3) begin
      @(negedge clk);
      chk("err sticky b", 32'(ifb.state), 32'd15);
      chk("err halted b", 32'(ifb.halted), 32'd1);
    end

    // Reset pulsed in the middle of a memory write.
    rst_b = 1'b0;
    @(negedge clk);
    chk("err reset b", 32'(ifb.state), 32'd0);
    rst_b = 1'b1;
    opc = 3'b100; opp = 2'b00;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (ifb.state == 5'd13) found = 1'b1;
    end
    chk("reach MEM_WR b", 32'(found), 32'd1);
    chk("mwrite before reset b", 32'(ifb.mwrite), 32'd1);
    chk("msel in MEM_WR b", 32'(ifb.msel), 32'd0);
    #2 rst_b = 1'b0;
    #1;
    chk("mwrite async drop b", 32'(ifb.mwrite), 32'd0);
    chk("async reset state b", 32'(ifb.state), 32'd0);
    chk("async reset strobes b", 32'(ob), 32'(exp_out(0, 3'b000, 2'b00)));
    @(negedge clk);
    chk("reset held state b", 32'(ifb.state), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
